uart_rx_fifo: RTL

Second-generation UART receiver. Configurable at run time for data length, parity mode and stop-bit count, with majority-vote bit sampling, per-character error flags and an internal receive FIFO. Frames arrive on serial_i; characters leave through a valid/ready stream toward the bus-side register block. Supersedes the single-byte ready/clear-ready receiver.

---
 rtl/uart_rx_fifo.sv | 293 +++++++++++++++++++++++++++++
 1 files changed

// File: rtl/uart_rx_fifo.sv
// -----------------------------------------------------------------------------
// uart_rx_fifo
// UART receiver with run-time frame configuration, majority-vote bit sampling,
// per-character error flags and a receive FIFO drained through a valid/ready
// stream.
//
// Optional feature macro: UART_RX_BREAK_DETECT_EN
//   When defined, the receiver recognises a break (all data bits 0, parity 0
//   if enabled, first stop bit 0). It pulses break_o for one cycle instead of
//   storing the frame, then waits for one full bit time of idle line.
//
// Ports:
//   clock_i          system clock, rising edge
//   reset_ni         asynchronous active-low reset
//   serial_i         asynchronous serial line, idle high
//   clock_divider_i  clock cycles per bit; values below 4 keep the receiver idle
//   data_bits_i      character length, clamped to 5..MAX_DATA_BITS
//   parity_en_i      parity bit present
//   parity_even_i    1 = even parity, 0 = odd parity
//   stop_bits_i      0 = one stop bit, 1 = two stop bits
//   data_o           FIFO head character, zero when the FIFO is empty
//   frame_err_o      FIFO head: a stop bit was sampled low
//   parity_err_o     FIFO head: parity mismatch
//   valid_o          FIFO non-empty
//   ready_i          head is consumed when valid_o && ready_i
//   fifo_level_o     current FIFO entry count, 0..FIFO_DEPTH
//   overrun_o        sticky: a character was dropped on a full FIFO
//   clear_overrun_i  level-sensitive clear of overrun_o (a new overrun wins)
//   break_o          (feature only) one-cycle break indication
// -----------------------------------------------------------------------------
module uart_rx_fifo #(
    parameter int CLOCK_DIVIDER_WIDTH = 16,
    parameter int MAX_DATA_BITS       = 9,
    parameter int FIFO_DEPTH          = 8
) (
    input  logic                           clock_i,
    input  logic                           reset_ni,
    input  logic                           serial_i,
    input  logic [CLOCK_DIVIDER_WIDTH-1:0] clock_divider_i,
    input  logic [3:0]                     data_bits_i,
    input  logic                           parity_en_i,
    input  logic                           parity_even_i,
    input  logic                           stop_bits_i,
    output logic [MAX_DATA_BITS-1:0]       data_o,
    output logic                           frame_err_o,
    output logic                           parity_err_o,
    output logic                           valid_o,
    input  logic                           ready_i,
    output logic [$clog2(FIFO_DEPTH):0]    fifo_level_o,
    output logic                           overrun_o,
    input  logic                           clear_overrun_i
`ifdef UART_RX_BREAK_DETECT_EN
    ,
    output logic                           break_o
`endif
);

    localparam int              AW          = $clog2(FIFO_DEPTH);
    localparam int              DW          = CLOCK_DIVIDER_WIDTH;
    localparam logic [3:0]      MAX_BITS    = 4'(MAX_DATA_BITS);
    localparam logic [DW-1:0]   MIN_DIVIDER = DW'(4);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        PUSH
`ifdef UART_RX_BREAK_DETECT_EN
        ,
        BREAK
`endif
    } state_t;

    typedef struct packed {
        logic [MAX_DATA_BITS-1:0] data;
        logic                     frame_err;
        logic                     parity_err;
    } entry_t;

    function automatic logic [3:0] clamp_bits(input logic [3:0] bits);
        if (bits < 4'd5)     return 4'd5;
        if (bits > MAX_BITS) return MAX_BITS;
        return bits;
    endfunction

    // ---------------------------------------------------------------- sync
    logic [1:0] sync_q;
    logic       line;

    // NOTE: clocked state uses non-blocking assignments so every flop samples
    // pre-edge values; blocking here would collapse the two synchronizer stages.
    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) sync_q <= 2'b11;
        else           sync_q <= {sync_q[0], serial_i};
    end

    assign line = sync_q[1];

    // ---------------------------------------------------------------- receiver
    state_t                   state_q;
    logic [DW-1:0]            cfg_div_q;
    logic [3:0]               cfg_bits_q;
    logic                     cfg_par_en_q;
    logic                     cfg_even_q;
    logic                     cfg_stop2_q;
    logic [DW-1:0]            timer_q;
    logic [3:0]               bit_cnt_q;
    logic [1:0]               samp_q;
    logic [MAX_DATA_BITS-1:0] data_q;
    logic                     frame_err_q;
    logic                     parity_err_q;
`ifdef UART_RX_BREAK_DETECT_EN
    logic                     par_bit_q;
    logic                     stop0_low_q;
    logic                     break_q;
`endif

    logic [DW-1:0] mid;
    logic          at_s0, at_s1, at_s2, bit_end, majority, last_stop, push_req;

    // NOTE: every always_comb output gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    always_comb begin
        mid       = cfg_div_q >> 1;
        at_s0     = (timer_q == mid - DW'(1));
        at_s1     = (timer_q == mid);
        at_s2     = (timer_q == mid + DW'(1));
        bit_end   = (timer_q == cfg_div_q - DW'(1));
        // Third vote is the live line value at mid+1, so the bit is known in
        // the same cycle as the last sample.
        majority  = (samp_q[0] & samp_q[1]) | (samp_q[0] & line) | (samp_q[1] & line);
        last_stop = (bit_cnt_q == {3'b000, cfg_stop2_q});
        push_req  = (state_q == PUSH);
`ifdef UART_RX_BREAK_DETECT_EN
        if (break_q) push_req = 1'b0;
`endif
    end

    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q      <= IDLE;
            cfg_div_q    <= '0;
            cfg_bits_q   <= 4'd8;
            cfg_par_en_q <= 1'b0;
            cfg_even_q   <= 1'b0;
            cfg_stop2_q  <= 1'b0;
            timer_q      <= '0;
            bit_cnt_q    <= '0;
            samp_q       <= 2'b11;
            data_q       <= '0;
            frame_err_q  <= 1'b0;
            parity_err_q <= 1'b0;
`ifdef UART_RX_BREAK_DETECT_EN
            par_bit_q    <= 1'b0;
            stop0_low_q  <= 1'b0;
            break_q      <= 1'b0;
`endif
        end else begin
            // Bit timer and the first two votes are shared by all bit states.
            if (state_q inside {START, DATA, PARITY, STOP}) begin
                timer_q <= bit_end ? '0 : timer_q + DW'(1);
                if (at_s0) samp_q[0] <= line;
                if (at_s1) samp_q[1] <= line;
            end

            case (state_q)
                IDLE: begin
                    if (!line && clock_divider_i >= MIN_DIVIDER) begin
                        cfg_div_q    <= clock_divider_i;
                        cfg_bits_q   <= clamp_bits(data_bits_i);
                        cfg_par_en_q <= parity_en_i;
                        cfg_even_q   <= parity_even_i;
                        cfg_stop2_q  <= stop_bits_i;
                        timer_q      <= DW'(1);   // this cycle is position 0
                        bit_cnt_q    <= '0;
                        data_q       <= '0;
                        frame_err_q  <= 1'b0;
                        parity_err_q <= 1'b0;
                        state_q      <= START;
                    end
                end
                START: begin
                    if (bit_end) state_q <= DATA;
                    // A high start vote is a glitch; this overrides bit_end.
                    if (at_s2 && majority) state_q <= IDLE;
                end
                DATA: begin
                    if (at_s2) data_q[bit_cnt_q] <= majority;
                    if (bit_end) begin
                        if (bit_cnt_q == cfg_bits_q - 4'd1) begin
                            bit_cnt_q <= '0;
                            state_q   <= cfg_par_en_q ? PARITY : STOP;
                        end else begin
                            bit_cnt_q <= bit_cnt_q + 4'd1;
                        end
                    end
                end
                PARITY: begin
                    if (at_s2) begin
                        parity_err_q <= (((^data_q) ^ majority) != !cfg_even_q);
`ifdef UART_RX_BREAK_DETECT_EN
                        par_bit_q    <= majority;
`endif
                    end
                    if (bit_end) state_q <= STOP;
                end
                STOP: begin
                    if (bit_end) bit_cnt_q <= 4'd1;
                    if (at_s2) begin
                        if (!majority) frame_err_q <= 1'b1;
`ifdef UART_RX_BREAK_DETECT_EN
                        if (bit_cnt_q == 4'd0) stop0_low_q <= !majority;
`endif
                        // Leave at the last vote without waiting out the bit.
                        if (last_stop) begin
                            state_q <= PUSH;
`ifdef UART_RX_BREAK_DETECT_EN
                            break_q <= (data_q == '0) && (!cfg_par_en_q || !par_bit_q) &&
                                       ((bit_cnt_q == 4'd0) ? !majority : stop0_low_q);
`endif
                        end
                    end
                end
                PUSH: begin
                    state_q <= IDLE;
`ifdef UART_RX_BREAK_DETECT_EN
                    break_q <= 1'b0;
                    if (break_q) begin
                        timer_q <= '0;
                        state_q <= BREAK;
                    end
`endif
                end
`ifdef UART_RX_BREAK_DETECT_EN
                BREAK: begin
                    // Count consecutive high cycles; any low restarts the bit time.
                    if (!line)                              timer_q <= '0;
                    else if (timer_q == cfg_div_q - DW'(1)) state_q <= IDLE;
                    else                                    timer_q <= timer_q + DW'(1);
                end
`endif
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef UART_RX_BREAK_DETECT_EN
    assign break_o = break_q;
`endif

    // ---------------------------------------------------------------- FIFO
    entry_t       mem_q [FIFO_DEPTH];
    entry_t       head;
    logic [AW:0]  wr_ptr_q, rd_ptr_q;
    logic         empty, full, pop, push, drop, overrun_q;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign pop   = !empty && ready_i;
    // A pop in the same cycle frees the slot the push needs.
    assign push  = push_req && (!full || pop);
    assign drop  = push_req && full && !pop;

    // NOTE: storage has no reset; the pointers alone define which entries are
    // valid, and the outputs are masked while the FIFO is empty.
    always_ff @(posedge clock_i) begin
        if (push) mem_q[wr_ptr_q[AW-1:0]] <= {data_q, frame_err_q, parity_err_q};
    end

    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            overrun_q <= 1'b0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            if (drop)                 overrun_q <= 1'b1;
            else if (clear_overrun_i) overrun_q <= 1'b0;
        end
    end

    assign head         = mem_q[rd_ptr_q[AW-1:0]];
    assign data_o       = empty ? '0 : head.data;
    assign frame_err_o  = !empty && head.frame_err;
    assign parity_err_o = !empty && head.parity_err;
    assign valid_o      = !empty;
    assign fifo_level_o = wr_ptr_q - rd_ptr_q;
    assign overrun_o    = overrun_q;

endmodule
